ptm_responder: RTL and testbench

Synthesizable far end of the pattern-matcher (PTM) read interface. It holds the pattern/answer memory, sequences the PTM's reset and start, and answers each `en`/`addr` request with the stored 10-bit data word in the same cycle. It also scores every returned `flag` against the stored expected bit and checks the final `result`. It sits opposite PTM in the on-chip self-test wrapper, replacing the simulation-only stimulus.

---
 rtl/ptm_pkg.sv | 23 ++
 rtl/ptm_resp_mem.sv | 25 ++
 rtl/ptm_responder.sv | 125 ++++++++++++
 tb/tb_ptm_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptm_pkg.sv
// Shared definitions for the pattern matcher and its responder.
// Widths, address map and the responder state encoding.
package ptm_pkg;

    localparam int DATA_W   = 11;
    localparam int ADDR_W   = 10;
    localparam int MAX_ADDR = 1023;
    localparam int ANS_ADDR = 1024;
    localparam int CNT_W    = 11;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        GAP,
        RUN,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ptm_resp_mem.sv
// Pattern/answer store: one sync write port, one async read port
// at the PTM address and a fixed read of the expected result word.
module ptm_resp_mem
    import ptm_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [10:0]       waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-2:0] ans
);

    logic [DATA_W-1:0] mem [0:ANS_ADDR];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[{1'b0, raddr}];
    assign ans   = mem[11'(ANS_ADDR)][DATA_W-1:1];

endmodule

// File: rtl/ptm_responder.sv
// Far end of the PTM read interface: sequences PTM reset/start,
// serves data with zero latency and scores every returned flag.
module ptm_responder
    import ptm_pkg::*;
#(
    parameter int START_GAP = 1,
    parameter int TIMEOUT   = 1 << 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [10:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              go,
    output logic              ptm_rst,
    output logic              ptm_start,
    input  logic              ptm_en,
    input  logic [ADDR_W-1:0] ptm_addr,
    output logic [ADDR_W-1:0] ptm_data,
    input  logic              ptm_flag,
    input  logic              ptm_fin,
    input  logic [ADDR_W-1:0] ptm_result,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam int GW = (START_GAP > 1) ? $clog2(START_GAP) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            st;
    logic [GW-1:0]     gcnt;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-2:0] ans;
    logic              rd_ok;
    logic              ld_ok;
    logic              score;

    assign rd_ok = ptm_en && ({1'b0, ptm_addr} <= 11'(MAX_ADDR));
    assign ld_ok = ld_en && (ld_addr <= 11'(ANS_ADDR))
                   && (st == IDLE || st == DONE);
    assign score = (st == RUN) && rd_ok && !ptm_fin;

    assign ptm_data = rd_ok ? rd[DATA_W-1:1] : '0;

    ptm_resp_mem u_mem (
        .clk   (clk),
        .we    (ld_ok),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (ptm_addr),
        .rdata (rd),
        .ans   (ans)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            ptm_rst   <= 1'b0;
            ptm_start <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            hit_cnt   <= '0;
            gcnt      <= '0;
            tcnt      <= '0;
        end else begin
            if (score) begin
                if (ptm_flag != rd[0])
                    err_cnt <= sat_inc(err_cnt);
                else if (rd[0])
                    hit_cnt <= sat_inc(hit_cnt);
            end
            unique case (st)
                IDLE, DONE: begin
                    if (go) begin
                        st      <= RESET;
                        ptm_rst <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        err_cnt <= '0;
                        hit_cnt <= '0;
                    end
                end
                RESET: begin
                    st      <= GAP;
                    ptm_rst <= 1'b0;
                    gcnt    <= '0;
                end
                GAP: begin
                    if (gcnt == GW'(START_GAP - 1)) begin
                        st        <= RUN;
                        ptm_start <= 1'b1;
                        tcnt      <= '0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                RUN: begin
                    tcnt <= tcnt + 1'b1;
                    // Finish wins over a timeout landing on the same edge.
                    if (ptm_fin) begin
                        st        <= DONE;
                        ptm_start <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_cnt == '0) && (ptm_result == ans);
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        st        <= DONE;
                        ptm_start <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptm_responder.sv
// Randomized bench for ptm_responder against a behavioural
// model of the run sequence, memory and scoreboard.
module tb_ptm_responder;

    localparam int TO  = 1500;
    localparam int GAPN = 1;

    localparam int S_IDLE  = 0;
    localparam int S_RESET = 1;
    localparam int S_GAP   = 2;
    localparam int S_RUN   = 3;
    localparam int S_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [10:0] ld_addr;
    logic [10:0] ld_data;
    logic        go;
    logic        ptm_rst;
    logic        ptm_start;
    logic        ptm_en;
    logic [9:0]  ptm_addr;
    logic [9:0]  ptm_data;
    logic        ptm_flag;
    logic        ptm_fin;
    logic [9:0]  ptm_result;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [10:0] err_cnt;
    logic [10:0] hit_cnt;

    ptm_responder #(.START_GAP(GAPN), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .go         (go),
        .ptm_rst    (ptm_rst),
        .ptm_start  (ptm_start),
        .ptm_en     (ptm_en),
        .ptm_addr   (ptm_addr),
        .ptm_data   (ptm_data),
        .ptm_flag   (ptm_flag),
        .ptm_fin    (ptm_fin),
        .ptm_result (ptm_result),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .err_cnt    (err_cnt),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] mm [0:1024];
    int          ms;
    int          merr;
    int          mhit;
    int          mgap;
    int          mrun;
    bit          mpass;
    bit          mto;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at one rising edge, from the current inputs.
    task automatic model();
        bit e;
        if (rst) begin
            ms = S_IDLE; merr = 0; mhit = 0; mpass = 0; mto = 0;
        end else begin
            case (ms)
                S_IDLE, S_DONE: begin
                    if (ld_en && ld_addr <= 11'd1024)
                        mm[ld_addr] = ld_data;
                    if (go) begin
                        ms = S_RESET; merr = 0; mhit = 0;
                        mpass = 0; mto = 0;
                    end
                end
                S_RESET: begin
                    ms = S_GAP; mgap = 0;
                end
                S_GAP: begin
                    mgap++;
                    if (mgap == GAPN) begin
                        ms = S_RUN; mrun = 0;
                    end
                end
                S_RUN: begin
                    mrun++;
                    if (ptm_fin) begin
                        ms = S_DONE;
                        mpass = (merr == 0) && (ptm_result == mm[1024][10:1]);
                    end else begin
                        if (ptm_en) begin
                            e = mm[ptm_addr][0];
                            if (ptm_flag != e) merr = (merr < 2047) ? merr + 1 : merr;
                            else if (e) mhit = (mhit < 2047) ? mhit + 1 : mhit;
                        end
                        if (mrun == TO) begin
                            ms = S_DONE; mto = 1; mpass = 0;
                        end
                    end
                end
                default: ms = S_IDLE;
            endcase
        end
    endtask

    task automatic step();
        logic [9:0] exp_d;
        #1;
        if (ms == S_RUN) begin
            exp_d = ptm_en ? mm[ptm_addr][10:1] : 10'd0;
            check("ptm_data", 32'(ptm_data), 32'(exp_d));
        end
        @(posedge clk);
        model();
        #1;
        go = 0; ld_en = 0; ptm_en = 0; ptm_fin = 0;
        check("ptm_rst", 32'(ptm_rst), 32'(ms == S_RESET));
        check("ptm_start", 32'(ptm_start), 32'(ms == S_RUN));
        check("done", 32'(done), 32'(ms == S_DONE));
        check("pass", 32'(pass), 32'(mpass));
        check("timeout", 32'(timeout), 32'(mto));
        check("err_cnt", 32'(err_cnt), 32'(merr));
        check("hit_cnt", 32'(hit_cnt), 32'(mhit));
    endtask

    task automatic launch();
        go = 1;
        step();
        check("rst_pulse", 32'(ptm_rst), 32'd1);
        step();
        check("rst_drop", 32'(ptm_rst), 32'd0);
        check("gap_nostart", 32'(ptm_start), 32'd0);
        step();
        check("start_up", 32'(ptm_start), 32'd1);
    endtask

    task automatic rnd(input bit bad);
        ptm_en   = ($urandom_range(0, 3) != 0);
        ptm_addr = 10'($urandom);
        ptm_flag = mm[ptm_addr][0] ^ (bad && ($urandom_range(0, 3) == 0));
    endtask

    task automatic sweep(input int b1, input int b2);
        for (int a = 0; a < 1024; a++) begin
            ptm_en   = 1;
            ptm_addr = 10'(a);
            ptm_flag = mm[a][0] ^ (a == b1 || a == b2);
            step();
        end
    endtask

    // Finish with a wrong flag on a live read in the same cycle.
    task automatic finish_run(input int delta);
        ptm_fin    = 1;
        ptm_result = 10'(int'(mm[1024][10:1]) + delta);
        ptm_en     = 1;
        ptm_addr   = 10'($urandom);
        ptm_flag   = ~mm[ptm_addr][0];
        step();
        check("fin_done", 32'(done), 32'd1);
        check("fin_nostart", 32'(ptm_start), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1; go = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
        ptm_en = 0; ptm_addr = 0; ptm_flag = 0; ptm_fin = 0; ptm_result = 0;
        ms = S_IDLE; merr = 0; mhit = 0; mgap = 0; mrun = 0;
        mpass = 0; mto = 0;
        step();
        step();
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 0;

        for (int a = 0; a <= 1024; a++) begin
            ld_en = 1; ld_addr = 11'(a); ld_data = 11'($urandom);
            step();
        end
        ld_en = 1; ld_addr = 11'd5; ld_data = {10'h2A, 1'b1};
        step();
        ld_en = 1; ld_addr = 11'd1500; ld_data = 11'h7FF;
        step();

        // Run A: directed read of address 5, clean sweep, correct result.
        launch();
        ptm_en = 1; ptm_addr = 10'd5; ptm_flag = 1;
        #1;
        check("data5", 32'(ptm_data), 32'h2A);
        step();
        check("hit5", 32'(hit_cnt), 32'd1);
        check("err5", 32'(err_cnt), 32'd0);
        sweep(-1, -1);
        finish_run(0);
        check("passA", 32'(pass), 32'd1);

        // Run B: two inverted flags.
        launch();
        sweep(7, 900);
        finish_run(0);
        check("errB", 32'(err_cnt), 32'd2);
        check("passB", 32'(pass), 32'd0);

        // Run C: random clean traffic, go ignored mid-run, result off by one.
        launch();
        for (int i = 0; i < 200; i++) begin
            rnd(0);
            if (i == 50) go = 1;
            step();
        end
        finish_run(1);
        check("errC", 32'(err_cnt), 32'd0);
        check("passC", 32'(pass), 32'd0);

        // Run D: no finish, random errors, run must time out.
        launch();
        n = 0;
        while (ms == S_RUN && n < TO + 5) begin
            rnd(1);
            step();
            n++;
        end
        check("to_len", 32'(n), 32'(TO));
        check("to_flag", 32'(timeout), 32'd1);
        check("to_pass", 32'(pass), 32'd0);
        check("to_done", 32'(done), 32'd1);

        // Run E: load ignored during RUN, reset mid-run, load afterwards.
        launch();
        for (int i = 0; i < 10; i++) begin
            rnd(1);
            step();
        end
        ld_en = 1; ld_addr = 11'd5; ld_data = {10'h155, 1'b0};
        rnd(1);
        step();
        rst = 1;
        step();
        check("rst_mid_start", 32'(ptm_start), 32'd0);
        check("rst_mid_err", 32'(err_cnt), 32'd0);
        check("rst_mid_rst", 32'(ptm_rst), 32'd0);
        rst = 0;
        launch();
        ptm_en = 1; ptm_addr = 10'd5; ptm_flag = 1;
        #1;
        check("data5_kept", 32'(ptm_data), 32'h2A);
        step();
        finish_run(0);
        check("passE", 32'(pass), 32'd1);
        ld_en = 1; ld_addr = 11'd5; ld_data = {10'h1C3, 1'b0};
        step();
        launch();
        ptm_en = 1; ptm_addr = 10'd5; ptm_flag = 0;
        #1;
        check("data5_new", 32'(ptm_data), 32'h1C3);
        step();
        finish_run(0);
        check("passF", 32'(pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
